parl_posl_tx: RTL and testbench

//  Parallel-to-serial transmitter; the stage directly upstream of the serial-to-parallel deserializer.

---
 rtl/posl_parl_pkg.sv | 5 +
 rtl/parl_posl_tx_if.sv | 7 +
 rtl/parl_posl_tx_piso_shift_reg.sv | 17 +
 rtl/parl_posl_tx.sv | 76 +++++++
 tb/tb_parl_posl_tx.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/posl_parl_pkg.sv
// posl_parl_pkg: state encodings and default word width shared by the serial link stages
package posl_parl_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_GAP = 2'd2} state_t;
endpackage

// File: rtl/parl_posl_tx_if.sv
// parl_posl_tx_if: parallel valid/ready word input plus the serial link toward the deserializer
interface parl_posl_tx_if import posl_parl_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) ();
  logic [WIDTH-1:0] par_data;
  logic par_valid, par_ready, ser_data, ser_enable, frame_done, busy;
  modport master (output par_data, par_valid, input par_ready, ser_data, ser_enable, frame_done, busy);
  modport slave (input par_data, par_valid, output par_ready, ser_data, ser_enable, frame_done, busy);
endinterface

// File: rtl/parl_posl_tx_piso_shift_reg.sv
// piso_shift_reg: loadable left-shift register exposing its MSB as the serial tap
module piso_shift_reg import posl_parl_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_msb
);
  logic [WIDTH-1:0] q;
  // load wins over shift so a back-to-back reload replaces the drained word
  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= '0;
    else if (load) q <= d;
    else if (shift) q <= {q[WIDTH-2:0], 1'b0};
  assign q_msb = q[WIDTH-1];
endmodule

// File: rtl/parl_posl_tx.sv
// parl_posl_tx: buffered parallel-to-serial transmitter, MSB first, optional inter-frame gap
module parl_posl_tx import posl_parl_pkg::*; #(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int GAP_CYCLES = 0
) (
  input logic           clk,
  input logic           reset,
  parl_posl_tx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [GW-1:0] gcnt, gcnt_nxt;
  logic [WIDTH-1:0] buf_q;
  logic buf_full, run, load, shift, accept, last, gap_end, q_msb;
  assign accept  = bus.par_valid & bus.par_ready;
  assign last    = cnt == CW'(WIDTH - 1);
  assign gap_end = gcnt == GW'(GAP_CYCLES - 1);
  // state, counters, holding buffer and the post-reset ready enable
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      gcnt     <= '0;
      buf_q    <= '0;
      buf_full <= 1'b0;
      run      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gcnt     <= gcnt_nxt;
      buf_q    <= accept ? bus.par_data : buf_q;
      buf_full <= accept | (buf_full & ~load);
      run      <= 1'b1;
    end
  // next state: drain the buffer into the shifter whenever a frame may start
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      ST_IDLE: begin
        load      = buf_full;
        state_nxt = buf_full ? ST_SHIFT : ST_IDLE;
      end
      ST_SHIFT: begin
        shift    = 1'b1;
        cnt_nxt  = last ? '0 : cnt + CW'(1);
        gcnt_nxt = '0;
        if (last) begin
          load      = GAP_CYCLES == 0 && buf_full;
          state_nxt = GAP_CYCLES > 0 ? ST_GAP : buf_full ? ST_SHIFT : ST_IDLE;
        end
      end
      ST_GAP: begin
        gcnt_nxt = gcnt + GW'(1);
        if (gap_end) begin
          load      = buf_full;
          state_nxt = buf_full ? ST_SHIFT : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
  piso_shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk(clk), .reset(reset), .load(load), .shift(shift), .d(buf_q), .q_msb(q_msb)
  );
  assign bus.par_ready  = run & ~buf_full;
  assign bus.ser_enable = state == ST_SHIFT;
  assign bus.ser_data   = (state == ST_SHIFT) & q_msb;
  assign bus.frame_done = (state == ST_SHIFT) & last;
  assign bus.busy       = (state != ST_IDLE) | buf_full;
endmodule

// File: tb/tb_parl_posl_tx.sv
// tb_parl_posl_tx: drives three transmitters and deserializes their outputs against the accepted words
module tb_parl_posl_tx;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;

  parl_posl_tx_if #(.WIDTH(8))  b8 ();
  parl_posl_tx_if #(.WIDTH(12)) b12 ();
  parl_posl_tx_if #(.WIDTH(8))  bg ();
  parl_posl_tx #(.WIDTH(8),  .GAP_CYCLES(0)) d8  (.clk(clk), .reset(reset), .bus(b8));
  parl_posl_tx #(.WIDTH(12), .GAP_CYCLES(0)) d12 (.clk(clk), .reset(reset), .bus(b12));
  parl_posl_tx #(.WIDTH(8),  .GAP_CYCLES(3)) dg  (.clk(clk), .reset(reset), .bus(bg));

  localparam int WD [3] = '{8, 12, 8};
  logic en [3], sd [3], fd [3], pv [3], pr [3];
  logic [11:0] pd [3];
  assign en[0] = b8.ser_enable, en[1] = b12.ser_enable, en[2] = bg.ser_enable;
  assign sd[0] = b8.ser_data,   sd[1] = b12.ser_data,   sd[2] = bg.ser_data;
  assign fd[0] = b8.frame_done, fd[1] = b12.frame_done, fd[2] = bg.frame_done;
  assign pv[0] = b8.par_valid,  pv[1] = b12.par_valid,  pv[2] = bg.par_valid;
  assign pr[0] = b8.par_ready,  pr[1] = b12.par_ready,  pr[2] = bg.par_ready;
  assign pd[0] = {4'b0, b8.par_data}, pd[1] = b12.par_data, pd[2] = {4'b0, bg.par_data};

  // reference deserializer per link: accepted words in, reassembled words out
  logic [11:0] acc [3] = '{12'd0, 12'd0, 12'd0};
  int nb [3] = '{0, 0, 0};
  int exn [3] = '{0, 0, 0};
  int rxn [3] = '{0, 0, 0};
  int fdn [3] = '{0, 0, 0};
  int fdbad [3] = '{0, 0, 0};
  logic [11:0] exq [3][2048];
  logic [11:0] rxq [3][2048];
  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (!reset) begin
        acc[i] <= '0;
        nb[i]  <= 0;
      end else begin
        if (pv[i] && pr[i]) begin
          exq[i][exn[i]] <= pd[i];
          exn[i] <= exn[i] + 1;
        end
        if (fd[i]) fdn[i] <= fdn[i] + 1;
        if (en[i] && nb[i] == WD[i] - 1) begin
          rxq[i][rxn[i]] <= {acc[i][10:0], sd[i]};
          rxn[i] <= rxn[i] + 1;
          acc[i] <= '0;
          nb[i]  <= 0;
          if (!fd[i]) fdbad[i] <= fdbad[i] + 1;
        end else if (en[i]) begin
          acc[i] <= {acc[i][10:0], sd[i]};
          nb[i]  <= nb[i] + 1;
          if (fd[i]) fdbad[i] <= fdbad[i] + 1;
        end else if (fd[i]) fdbad[i] <= fdbad[i] + 1;
      end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    b8.par_valid = 1'b1;  b8.par_data = 8'h5A;
    b12.par_valid = 1'b1; b12.par_data = 12'hABC;
    bg.par_valid = 1'b1;  bg.par_data = 8'h77;
    repeat (3) @(negedge clk);
    n_cmp++; if ({b8.par_ready, b8.ser_data, b8.ser_enable, b8.frame_done, b8.busy} !== 5'b0) begin n_bad++; $display("FAIL reset_outs_w8 got %b want 00000", {b8.par_ready, b8.ser_data, b8.ser_enable, b8.frame_done, b8.busy}); end
    n_cmp++; if ({b12.par_ready, b12.ser_data, b12.ser_enable, b12.frame_done, b12.busy} !== 5'b0) begin n_bad++; $display("FAIL reset_outs_w12 got %b want 00000", {b12.par_ready, b12.ser_data, b12.ser_enable, b12.frame_done, b12.busy}); end
    n_cmp++; if ({bg.par_ready, bg.ser_data, bg.ser_enable, bg.frame_done, bg.busy} !== 5'b0) begin n_bad++; $display("FAIL reset_outs_gap got %b want 00000", {bg.par_ready, bg.ser_data, bg.ser_enable, bg.frame_done, bg.busy}); end
    b8.par_valid = 1'b0; b12.par_valid = 1'b0; bg.par_valid = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (b8.par_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_clk got %b want 0", b8.par_ready); end
    @(negedge clk);
    n_cmp++; if ({b8.par_ready, b12.par_ready, bg.par_ready} !== 3'b111) begin n_bad++; $display("FAIL ready_after_clk got %b want 111", {b8.par_ready, b12.par_ready, bg.par_ready}); end
    n_cmp++; if ({b8.busy, b12.busy, bg.busy} !== 3'b000) begin n_bad++; $display("FAIL reset_no_transfer busy got %b want 000", {b8.busy, b12.busy, bg.busy}); end
  endtask

  task automatic test_single();
    logic [7:0] bits = '0;
    int first = -1, fdk = -1, n = 0, rb, fb;
    tick();
    rb = rxn[0]; fb = fdn[0];
    n_cmp++; if (b8.par_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got %b want 1", b8.par_ready); end
    b8.par_data = 8'hA5; b8.par_valid = 1'b1;
    tick();
    b8.par_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b8.ser_enable) begin
        if (first < 0) first = k;
        bits = {bits[6:0], b8.ser_data};
        n++;
      end
      if (b8.frame_done) fdk = k;
    end
    tick();
    n_cmp++; if (first != 1) begin n_bad++; $display("FAIL single_latency got %0d want 1", first); end
    n_cmp++; if (n != 8) begin n_bad++; $display("FAIL single_bitcount got %0d want 8", n); end
    n_cmp++; if (bits !== 8'hA5) begin n_bad++; $display("FAIL single_bits got %h want a5", bits); end
    n_cmp++; if (fdk != 8) begin n_bad++; $display("FAIL single_frame_done cycle got %0d want 8", fdk); end
    n_cmp++; if (rxn[0] != rb + 1 || rxq[0][rb] !== 12'h0A5) begin n_bad++; $display("FAIL single_deser got %h (n=%0d) want a5", rxq[0][rb], rxn[0] - rb); end
    n_cmp++; if (fdn[0] != fb + 1) begin n_bad++; $display("FAIL single_fd_pulses got %0d want 1", fdn[0] - fb); end
  endtask

  task automatic test_back_to_back();
    logic en_tr [24], rd_tr [24];
    int sent = 0, first = -1, last = -1, cnt = 0, rb, fb, bb;
    bit fire;
    rb = rxn[0]; fb = fdn[0]; bb = fdbad[0];
    b8.par_data = 8'h3C; b8.par_valid = 1'b1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      en_tr[c] = b8.ser_enable; rd_tr[c] = b8.par_ready;
      fire = b8.par_valid && b8.par_ready;
      if (en_tr[c]) begin cnt++; last = c; if (first < 0) first = c; end
      tick();
      if (fire) begin
        sent++;
        if (sent == 1) b8.par_data = 8'hC3; else b8.par_valid = 1'b0;
      end
    end
    if (first < 0) first = 0;
    n_cmp++; if (cnt != 16) begin n_bad++; $display("FAIL b2b_enable_count got %0d want 16", cnt); end
    n_cmp++; if (last - first + 1 != 16) begin n_bad++; $display("FAIL b2b_contiguous span got %0d want 16", last - first + 1); end
    n_cmp++; if ({rd_tr[first + 1], rd_tr[first + 7], rd_tr[first + 8]} !== 3'b001) begin n_bad++; $display("FAIL b2b_ready_trace got %b want 001", {rd_tr[first + 1], rd_tr[first + 7], rd_tr[first + 8]}); end
    n_cmp++; if (rxn[0] != rb + 2 || rxq[0][rb] !== 12'h03C || rxq[0][rb + 1] !== 12'h0C3) begin n_bad++; $display("FAIL b2b_deser got %h %h (n=%0d) want 3c c3", rxq[0][rb], rxq[0][rb + 1], rxn[0] - rb); end
    n_cmp++; if (fdn[0] - fb != 2 || fdbad[0] != bb) begin n_bad++; $display("FAIL b2b_frame_done pulses %0d misplaced %0d want 2 0", fdn[0] - fb, fdbad[0] - bb); end
  endtask

  task automatic test_gap();
    logic tr [30];
    int sent = 0, p = 0, s, l1, g, l2, rb, fb, bb;
    bit fire;
    rb = rxn[2]; fb = fdn[2]; bb = fdbad[2];
    bg.par_data = 8'hFF; bg.par_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      tr[c] = bg.ser_enable;
      fire = bg.par_valid && bg.par_ready;
      tick();
      if (fire) begin
        sent++;
        if (sent == 1) bg.par_data = 8'h01; else bg.par_valid = 1'b0;
      end
    end
    while (p < 30 && !tr[p]) p++;
    s = p; while (p < 30 && tr[p]) p++; l1 = p - s;
    s = p; while (p < 30 && !tr[p]) p++; g = p - s;
    s = p; while (p < 30 && tr[p]) p++; l2 = p - s;
    n_cmp++; if (l1 != 8 || l2 != 8) begin n_bad++; $display("FAIL gap_frame_len got %0d,%0d want 8,8", l1, l2); end
    n_cmp++; if (g != 3) begin n_bad++; $display("FAIL gap_idle_cycles got %0d want 3", g); end
    n_cmp++; if (fdn[2] - fb != 2 || fdbad[2] != bb) begin n_bad++; $display("FAIL gap_frame_done pulses %0d misplaced %0d want 2 0", fdn[2] - fb, fdbad[2] - bb); end
    n_cmp++; if (rxn[2] != rb + 2 || rxq[2][rb] !== 12'h0FF || rxq[2][rb + 1] !== 12'h001) begin n_bad++; $display("FAIL gap_deser got %h %h want ff 01", rxq[2][rb], rxq[2][rb + 1]); end
  endtask

  task automatic test_reset_mid();
    int sent = 0, ne = 0, seen = 0, rb, fb, bb;
    bit fire;
    rb = rxn[0]; fb = fdn[0]; bb = fdbad[0];
    b8.par_data = 8'h96; b8.par_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      fire = b8.par_valid && b8.par_ready;
      if (b8.ser_enable) ne++;
      if (ne == 4 && sent == 2) break;
      tick();
      if (fire) begin
        sent++;
        if (sent == 1) b8.par_data = 8'h5A; else b8.par_valid = 1'b0;
      end
    end
    n_cmp++; if ({b8.ser_enable, b8.busy, b8.par_ready} !== 3'b110) begin n_bad++; $display("FAIL midrst_pre en/busy/ready got %b want 110", {b8.ser_enable, b8.busy, b8.par_ready}); end
    #1 reset = 1'b0;
    #1;
    n_cmp++; if ({b8.ser_enable, b8.ser_data, b8.frame_done, b8.busy, b8.par_ready} !== 5'b0) begin n_bad++; $display("FAIL midrst_async got %b want 00000", {b8.ser_enable, b8.ser_data, b8.frame_done, b8.busy, b8.par_ready}); end
    repeat (2) tick();
    reset = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (b8.ser_enable || b8.frame_done) seen++;
    end
    tick();
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL midrst_no_resume active cycles got %0d want 0", seen); end
    n_cmp++; if (fdn[0] != fb || rxn[0] != rb || fdbad[0] != bb) begin n_bad++; $display("FAIL midrst_no_frame fd %0d words %0d want 0 0", fdn[0] - fb, rxn[0] - rb); end
    n_cmp++; if ({b8.busy, b8.par_ready} !== 2'b01) begin n_bad++; $display("FAIL midrst_idle busy/ready got %b want 01", {b8.busy, b8.par_ready}); end
  endtask

  task automatic apply(input int i, input logic v, input logic [11:0] d);
    if (i == 0) begin b8.par_valid = v; b8.par_data = d[7:0]; end
    else begin b12.par_valid = v; b12.par_data = d; end
  endtask

  task automatic drive_rand(input int i, output int sent);
    logic v = 1'b1;
    logic [11:0] d = 12'($urandom);
    int s = 0;
    bit fire;
    apply(i, v, d);
    for (int c = 0; c < 60000 && s < 1000; c++) begin
      @(negedge clk);
      fire = pv[i] && pr[i];
      tick();
      if (fire) begin
        s++;
        d = 12'($urandom);
        v = s < 1000 && $urandom_range(0, 3) != 0;
      end else if (!v) v = 1'($urandom_range(0, 1));
      apply(i, v, d);
    end
    apply(i, 1'b0, d);
    sent = s;
  endtask

  task automatic test_random();
    int s0, s1, eb [2], rb [2], fb [2], bb [2], errs, idle = 0;
    for (int i = 0; i < 2; i++) begin eb[i] = exn[i]; rb[i] = rxn[i]; fb[i] = fdn[i]; bb[i] = fdbad[i]; end
    fork
      drive_rand(0, s0);
      drive_rand(1, s1);
    join
    for (int c = 0; c < 200 && !idle; c++) begin
      tick();
      idle = !b8.busy && !b12.busy;
    end
    tick();
    n_cmp++; if (s0 != 1000 || s1 != 1000 || !idle) begin n_bad++; $display("FAIL random_timeout sent %0d/%0d idle %0d want 1000/1000 1", s0, s1, idle); end
    for (int i = 0; i < 2; i++) begin
      errs = 0;
      for (int k = 0; k < 1000; k++)
        if (rxq[i][rb[i] + k] !== exq[i][eb[i] + k]) begin
          if (errs == 0) $display("FAIL random_word_w%0d idx %0d got %h want %h", WD[i], k, rxq[i][rb[i] + k], exq[i][eb[i] + k]);
          errs++;
        end
      n_cmp++; if (rxn[i] - rb[i] != 1000 || exn[i] - eb[i] != 1000) begin n_bad++; $display("FAIL random_count_w%0d rx %0d acc %0d want 1000", WD[i], rxn[i] - rb[i], exn[i] - eb[i]); end
      n_cmp++; if (errs != 0) begin n_bad++; $display("FAIL random_scoreboard_w%0d bad words %0d want 0", WD[i], errs); end
      n_cmp++; if (fdn[i] - fb[i] != 1000 || fdbad[i] != bb[i]) begin n_bad++; $display("FAIL random_frame_done_w%0d pulses %0d misplaced %0d want 1000 0", WD[i], fdn[i] - fb[i], fdbad[i] - bb[i]); end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
